dmi_arbiter: RTL

Two-port arbiter sharing the single Debug Module DMI ready/valid request/response channel between two debug transports, for example the UART DMI front end and a JTAG DTM. It accepts one request at a time using round-robin arbitration and forwards it to the DM. It returns the DM response only to the requester that issued the request. An optional timeout keeps a hung DM from stalling the link forever.

---
 rtl/dmi_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DM DMI request/response channel between two debug transports.
// Optional DM-response timeout is compiled in with DMI_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a requester; picks the round-robin winner
// ISSUE     | presenting the latched request to the DM
// WAIT_RESP | waiting for the DM response (or the timeout, when compiled in)
// DELIVER   | presenting the captured response to the owning requester
module dmi_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        REQ0_VALID_I,
   output logic        REQ0_READY_O,
   input  logic [40:0] REQ0_I,
   output logic        RESP0_VALID_O,
   input  logic        RESP0_READY_I,
   output logic [33:0] RESP0_O,
   input  logic        REQ1_VALID_I,
   output logic        REQ1_READY_O,
   input  logic [40:0] REQ1_I,
   output logic        RESP1_VALID_O,
   input  logic        RESP1_READY_I,
   output logic [33:0] RESP1_O,
   output logic        DMI_REQ_VALID_O,
   input  logic        DMI_REQ_READY_I,
   output logic [40:0] DMI_REQ_O,
   input  logic        DMI_RESP_VALID_I,
   output logic        DMI_RESP_READY_O,
   input  logic [33:0] DMI_RESP_I,
   output logic        GRANT_O,
   output logic        BUSY_O
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DELIVER} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("dmi_arbiter: TIMEOUT_CYCLES must be in 1..65535");
   end

   state_t      state_q, state_d;
   logic [40:0] req_q, req_d;
   logic [33:0] resp_q, resp_d;
   logic        last_grant_q, last_grant_d;
   logic        winner;
   logic        stale;
   logic        timeout_hit;

`ifdef DMI_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

   logic        stale_q, stale_d;
   logic [15:0] cnt_q, cnt_d;

   assign stale       = stale_q;
   assign timeout_hit = (state_q == WAIT_RESP) && !DMI_RESP_VALID_I && (cnt_q == TO_LIMIT);

   always_comb begin
      stale_d = stale_q;
      cnt_d   = cnt_q;
      if (state_q == ISSUE && DMI_REQ_READY_I) begin
         cnt_d = '0;
      end else if (state_q == WAIT_RESP && !DMI_RESP_VALID_I) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (timeout_hit) begin
         stale_d = 1'b1;
      end else if (stale_q && DMI_RESP_VALID_I && (state_q == IDLE || state_q == DELIVER)) begin
         // late response of the abandoned transaction: swallowed here
         stale_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         stale_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         stale_q <= stale_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign stale       = 1'b0;
   assign timeout_hit = 1'b0;
`endif

   // tie goes to the requester that was not served last
   assign winner = (REQ0_VALID_I && REQ1_VALID_I) ? ~last_grant_q : REQ1_VALID_I;

   always_comb begin
      state_d          = state_q;
      req_d            = req_q;
      resp_d           = resp_q;
      last_grant_d     = last_grant_q;
      REQ0_READY_O     = 1'b0;
      REQ1_READY_O     = 1'b0;
      DMI_REQ_VALID_O  = 1'b0;
      DMI_RESP_READY_O = 1'b0;
      RESP0_VALID_O    = 1'b0;
      RESP1_VALID_O    = 1'b0;
      case (state_q)
         IDLE: begin
            DMI_RESP_READY_O = stale;
            if (!stale && (REQ0_VALID_I || REQ1_VALID_I)) begin
               REQ0_READY_O = ~winner;
               REQ1_READY_O = winner;
               req_d        = winner ? REQ1_I : REQ0_I;
               last_grant_d = winner;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            DMI_REQ_VALID_O = 1'b1;
            if (DMI_REQ_READY_I) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            DMI_RESP_READY_O = 1'b1;
            if (DMI_RESP_VALID_I) begin
               resp_d  = DMI_RESP_I;
               state_d = DELIVER;
            end else if (timeout_hit) begin
               resp_d  = {32'h0, 2'b10};
               state_d = DELIVER;
            end
         end
         DELIVER: begin
            DMI_RESP_READY_O = stale;
            RESP0_VALID_O    = ~last_grant_q;
            RESP1_VALID_O    = last_grant_q;
            if (last_grant_q ? RESP1_READY_I : RESP0_READY_I) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q      <= IDLE;
         req_q        <= '0;
         resp_q       <= '0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         resp_q       <= resp_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign DMI_REQ_O = req_q;
   assign RESP0_O   = resp_q;
   assign RESP1_O   = resp_q;
   assign GRANT_O   = last_grant_q;
   assign BUSY_O    = (state_q != IDLE) || stale;

endmodule
